// File: rtl/wptr_pkg.sv
// Shared helpers for the async FIFO write-side pointer logic: Gray/binary
// conversion sized by a width argument, plus the drop-counter width.
package wptr_pkg;

  localparam int unsigned MAX_PTR_W  = 17;
  localparam int unsigned DROP_CNT_W = 16;

  function automatic logic [MAX_PTR_W-1:0] width_mask(input int unsigned w);
    logic [MAX_PTR_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PTR_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b,
                                                    input int unsigned w);
    logic [MAX_PTR_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g,
                                                    input int unsigned w);
    logic [MAX_PTR_W-1:0] gm;
    logic [MAX_PTR_W-1:0] b;
    gm = g & width_mask(w);
    b  = '0;
    for (int i = 0; i < MAX_PTR_W; i++) begin
      b[i] = ^(gm >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational Gray-to-binary converter used on the synchronised read pointer.
module gray2bin_comb
  import wptr_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  assign o_bin = W'(gray2bin(MAX_PTR_W'(i_gray), W));

endmodule

// File: rtl/wptr_full_level.sv
// Write-domain pointer/flag controller for the async FIFO: write address, Gray
// pointer, full, almost-full, fill level and sticky overflow.
// Optional drop counter is compiled in with `define WPTR_DROP_CNT_EN.
module wptr_full_level
  import wptr_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AFULL_RST = 2**ADDR_W - 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_inc,
  input  logic [ADDR_W:0]       rd_ptr_sync,
  input  logic [ADDR_W:0]       afull_thresh,
  input  logic                  clr_ovf,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [ADDR_W:0]       wr_ptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_W:0]       wr_level,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] r_wbin;
  logic [PTR_W-1:0] r_wgray;
  logic             r_full;
  logic             r_afull;
  logic [PTR_W-1:0] r_level;
  logic             r_ovf;

  logic             w_push;
  logic             w_ovf_set;
  logic [PTR_W-1:0] w_wbin_next;
  logic [PTR_W-1:0] w_wgray_next;
  logic [PTR_W-1:0] w_rbin;
  logic [PTR_W-1:0] w_full_cmp;
  logic [PTR_W-1:0] w_level_next;
  logic [PTR_W-1:0] w_thr;
  logic             w_full_next;
  logic             w_afull_next;

  gray2bin_comb #(.W(PTR_W)) u_rd_g2b (
    .i_gray (rd_ptr_sync),
    .o_bin  (w_rbin)
  );

  assign w_push       = wr_inc & ~r_full;
  assign w_ovf_set    = wr_inc & r_full;
  assign w_wbin_next  = r_wbin + PTR_W'(w_push);
  assign w_wgray_next = PTR_W'(bin2gray(MAX_PTR_W'(w_wbin_next), PTR_W));

  // Full when the write pointer has lapped the read pointer by exactly one
  // trip: top two Gray bits inverted, the rest equal.
  assign w_full_cmp   = {~rd_ptr_sync[ADDR_W:ADDR_W-1], rd_ptr_sync[ADDR_W-2:0]};
  assign w_full_next  = (w_wgray_next == w_full_cmp);

  assign w_level_next = w_wbin_next - w_rbin;
  assign w_thr        = (afull_thresh == '0) ? PTR_W'(AFULL_RST) : afull_thresh;
  assign w_afull_next = (w_level_next >= w_thr);

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_level <= '0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
      r_afull <= w_afull_next;
      r_level <= w_level_next;
    end
  end

  // A write rejected for fullness in the same cycle as a clear keeps the flag set.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef WPTR_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_drop_cnt <= '0;
    end else if (w_ovf_set) begin
      if (clr_ovf) begin
        r_drop_cnt <= DROP_CNT_W'(1);
      end else if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
        r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
    end else if (clr_ovf) begin
      r_drop_cnt <= '0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

  assign wr_en       = w_push;
  assign wr_addr     = r_wbin[ADDR_W-1:0];
  assign wr_ptr      = r_wgray;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign wr_level    = r_level;
  assign overflow    = r_ovf;

endmodule

// File: doc/wptr_full_level.md
Name: wptr_full_level

Overview:
- Parametrised write-side pointer/flag controller for the async FIFO; successor to the basic write-pointer/full block.
- Sits entirely in the write clock domain:
  - generates the binary RAM write address and the Gray write pointer sent to the read domain;
  - takes the already-synchronised Gray read pointer.
- Adds to plain full: gated memory write enable, registered fill level, programmable almost-full, sticky overflow error.

Parameters:
- ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W; legal range 2..16.
- AFULL_RST, 2**ADDR_W-2, reset/default value used when afull_thresh is 0.

Ports:
- wr_clk  in  1  write-domain clock, rising edge.
- wr_rst  in  1  asynchronous, active-high reset.
- wr_inc  in  1  write request from producer.
- rd_ptr_sync  in  ADDR_W+1  Gray read pointer, already 2-FF synchronised to wr_clk.
- afull_thresh  in  ADDR_W+1  almost-full level threshold; 0 selects AFULL_RST.
- clr_ovf  in  1  clears sticky overflow (and drop counter when compiled in).
- wr_en  out  1  RAM write strobe, combinational = wr_inc & ~full.
- wr_addr  out  ADDR_W  RAM write address = wbin[ADDR_W-1:0].
- wr_ptr  out  ADDR_W+1  registered Gray write pointer for the read-domain synchroniser.
- full  out  1  registered full flag.
- almost_full  out  1  registered, level >= effective threshold.
- wr_level  out  ADDR_W+1  registered occupancy as seen from write side, 0..2**ADDR_W.
- overflow  out  1  sticky; write attempted while full.
- drop_cnt  out  16  dropped-write count (see Optional Feature).

Behaviour:
- Reset (async, wr_rst=1): wbin=0, wr_ptr=0, full=0, almost_full=0, wr_level=0, overflow=0, drop_cnt=0. wr_en follows wr_inc & ~full, so it is wr_inc during reset.
- push = wr_inc & ~full; wbin_next = wbin + push (mod 2**(ADDR_W+1)); wgray_next = (wbin_next>>1) ^ wbin_next.
- Each wr_clk edge: wbin<=wbin_next, wr_ptr<=wgray_next; wr_ptr changes by exactly one Gray bit per accepted write, never more.
- full_next = (wgray_next == {~rd_ptr_sync[ADDR_W:ADDR_W-1], rd_ptr_sync[ADDR_W-2:0]}); full<=full_next.
  - full asserts on the same edge that accepts the last free slot.
  - Zero-cycle write-to-full latency.
- rbin = Gray-to-binary(rd_ptr_sync), combinational; level_next = wbin_next - rbin (mod 2**(ADDR_W+1)); wr_level<=level_next.
- thr = (afull_thresh==0) ? AFULL_RST : afull_thresh; almost_full<=(level_next >= thr). A thr above depth means almost_full never asserts.
- Flags are pessimistic: read-side progress is seen 2+ cycles late; full/almost_full deassert only when rd_ptr_sync advances.
- Write while full: wr_en=0, pointers unchanged, overflow<=1 on that edge.
  - clr_ovf clears overflow.
  - Simultaneous set and clr_ovf: set wins, overflow stays 1.
- Wrap-around: wbin 2**(ADDR_W+1)-1 -> 0 is seamless; level and full are correct across the wrap.
- rd_ptr_sync illegal (level_next > depth) is not checked; behaviour is undefined, with no X propagation from control logic.
- Reset mid-operation: all state clears immediately, asynchronously. No write is accepted on the release edge unless wr_inc=1 and full=0. Read side must be reset concurrently.

Optional Feature:
- Macro WPTR_DROP_CNT_EN.
- Defined:
  - drop_cnt increments on every cycle with wr_inc & full;
  - saturates at 16'hFFFF;
  - cleared by clr_ovf; increment wins over clear in the same cycle, giving a result of 1.
- Undefined: drop_cnt tied to 0, no counter flops inferred.

Decomposition:
- Package wptr_pkg holds:
  - functions bin2gray and gray2bin, parametrised by width;
  - localparam DROP_CNT_W=16.
- One sub-module, gray2bin_comb (combinational Gray-to-binary, width parameter), converts rd_ptr_sync to rbin.
- Pointer, flag, level and overflow logic stay in the top module.

Test Plan:
- ADDR_W=4, rd_ptr_sync=0, 16 consecutive wr_inc, afull_thresh=0 (thr=14) ->
  - almost_full=1 after the 14th edge;
  - full=1, wr_level=16, wr_ptr=5'b11000 after the 16th edge;
  - wr_addr cycles 0..15.
- Continue wr_inc 3 cycles while full -> wr_en=0, wr_ptr unchanged, overflow=1, drop_cnt=3 (macro on) or 0 (off); pulse clr_ovf -> overflow=0, drop_cnt=0.
- From full, set rd_ptr_sync=5'b00110 (read bin 4) -> next edge full=0, wr_level=12, almost_full=0.
- Streaming 40 writes with rd_ptr_sync tracking Gray(wbin-3) -> wr_ptr wraps 5'b10000->5'b00000, wr_level stays 3, full never asserts.
- afull_thresh=5: 5 writes -> almost_full=1 on the 5th edge; afull_thresh=17 -> almost_full stays 0 at full.
- Assert wr_rst mid-stream between edges -> wr_ptr, full, wr_level, overflow go to 0 immediately; first write after release -> wr_addr=0, wr_ptr=5'b00001.
